// File: rtl/mem_phase_ctrl.sv
//------------------------------------------------------------------------------
// Module      : mem_phase_ctrl
// Description : Multi-cycle memory phase controller for a single-port RAM.
//               Sequences instruction fetch, execute decode, data load and
//               store, with a per-access wait timeout and alignment checks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_phase_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic [31:0] alu_addr,
   input  logic [31:0] store_data,
   input  logic        load_req,
   input  logic        store_req,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ready,
   output logic [29:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic        ram_re,
   output logic        ram_we,
   output logic        E,
   output logic [31:0] instr,
   output logic [31:0] load_data,
   output logic        pc_en,
   output logic        gpr_we_en,
   output logic        addr_err,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      LOAD  = 2'd2,
      STORE = 2'd3
   } state_t;

   localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

   state_t     r_state;
   logic [7:0] r_wait_cnt;
   logic       w_timeout;
   logic       w_bad_req;
   logic       w_unused;

   // Byte offset of the PC is irrelevant: fetches are always word accesses.
   assign w_unused  = ^pc[1:0];

   // Threshold reached with no completion; a ready in the same cycle wins.
   assign w_timeout = (r_wait_cnt == c_wait_last) && !ram_ready;

   // Conflicting or misaligned data request aborts the memory phase.
   assign w_bad_req = (load_req && store_req) ||
                      ((load_req || store_req) && (alu_addr[1:0] != 2'b00));

   // Phase sequencing, wait counting, latches and one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= FETCH;
         r_wait_cnt <= 8'd0;
         instr      <= 32'd0;
         load_data  <= 32'd0;
         pc_en      <= 1'b0;
         gpr_we_en  <= 1'b0;
         addr_err   <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         pc_en     <= 1'b0;
         gpr_we_en <= 1'b0;
         addr_err  <= 1'b0;
         bus_err   <= 1'b0;
         case (r_state)
            FETCH: begin
               if (ram_ready) begin
                  instr      <= ram_rdata;
                  r_state    <= EXEC;
                  r_wait_cnt <= 8'd0;
               end else if (w_timeout) begin
                  // Retry the same PC: no advance on a failed fetch.
                  bus_err    <= 1'b1;
                  r_state    <= FETCH;
                  r_wait_cnt <= 8'd0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            EXEC: begin
               r_wait_cnt <= 8'd0;
               if (!load_req && !store_req) begin
                  gpr_we_en <= 1'b1;
                  pc_en     <= 1'b1;
                  r_state   <= FETCH;
               end else if (w_bad_req) begin
                  addr_err  <= 1'b1;
                  pc_en     <= 1'b1;
                  r_state   <= FETCH;
               end else if (load_req) begin
                  r_state   <= LOAD;
               end else begin
                  r_state   <= STORE;
               end
            end
            LOAD: begin
               if (ram_ready) begin
                  load_data  <= ram_rdata;
                  gpr_we_en  <= 1'b1;
                  pc_en      <= 1'b1;
                  r_state    <= FETCH;
                  r_wait_cnt <= 8'd0;
               end else if (w_timeout) begin
                  bus_err    <= 1'b1;
                  pc_en      <= 1'b1;
                  r_state    <= FETCH;
                  r_wait_cnt <= 8'd0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            STORE: begin
               if (ram_ready) begin
                  pc_en      <= 1'b1;
                  r_state    <= FETCH;
                  r_wait_cnt <= 8'd0;
               end else if (w_timeout) begin
                  bus_err    <= 1'b1;
                  pc_en      <= 1'b1;
                  r_state    <= FETCH;
                  r_wait_cnt <= 8'd0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            default: begin
               r_state    <= FETCH;
               r_wait_cnt <= 8'd0;
            end
         endcase
      end
   end

   // RAM strobes and phase flag decoded from state; reset forces them idle.
   always_comb begin
      ram_re    = 1'b0;
      ram_we    = 1'b0;
      E         = 1'b0;
      ram_addr  = alu_addr[31:2];
      ram_wdata = store_data;
      if (rst) begin
         E = 1'b1;
      end else begin
         case (r_state)
            FETCH: begin
               ram_re   = 1'b1;
               E        = 1'b1;
               ram_addr = pc[31:2];
            end
            LOAD:    ram_re = 1'b1;
            STORE:   ram_we = 1'b1;
            default: ram_re = 1'b0;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_phase_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_phase_ctrl
// Description : Self-checking bench for mem_phase_ctrl: directed scenarios
//               followed by randomized traffic, compared each cycle against
//               an instruction-level behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_phase_ctrl;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, alu_addr, store_data, ram_rdata;
   logic        load_req, store_req, ram_ready;
   logic [29:0] ram_addr;
   logic [31:0] ram_wdata, instr, load_data;
   logic        ram_re, ram_we, E, pc_en, gpr_we_en, addr_err, bus_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: what the instruction is currently doing and what it has produced.
   // phase: 0 fetching, 1 deciding, 2 reading data, 3 writing data
   int          m_phase;
   int          m_spent;      // cycles already spent waiting in this access
   bit          m_valid = 0;  // model defined once a reset edge has occurred
   logic [31:0] m_instr, m_load;
   bit          m_pc_en, m_gpr, m_aerr, m_berr;

   mem_phase_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .pc(pc), .alu_addr(alu_addr),
      .store_data(store_data), .load_req(load_req), .store_req(store_req),
      .ram_rdata(ram_rdata), .ram_ready(ram_ready), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we), .E(E),
      .instr(instr), .load_data(load_data), .pc_en(pc_en),
      .gpr_we_en(gpr_we_en), .addr_err(addr_err), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model for the current inputs.
   task automatic compare_model();
      bit exp_re, exp_we, exp_e;
      exp_re = !rst && (m_phase == 0 || m_phase == 2);
      exp_we = !rst && (m_phase == 3);
      exp_e  = rst || (m_phase == 0);
      check("m_ram_re", ram_re, exp_re);
      check("m_ram_we", ram_we, exp_we);
      check("m_E", E, exp_e);
      check("m_instr", instr, m_instr);
      check("m_load_data", load_data, m_load);
      check("m_pc_en", pc_en, m_pc_en);
      check("m_gpr_we_en", gpr_we_en, m_gpr);
      check("m_addr_err", addr_err, m_aerr);
      check("m_bus_err", bus_err, m_berr);
      if (exp_re || exp_we)
         check("m_ram_addr", ram_addr, (m_phase == 0) ? {2'b00, pc[31:2]} : {2'b00, alu_addr[31:2]});
      if (exp_we)
         check("m_ram_wdata", ram_wdata, store_data);
   endtask

   // Advance the model by one clock edge using the inputs at that edge.
   task automatic step_model();
      bit done, expired;
      if (rst) begin
         m_valid = 1; m_phase = 0; m_spent = 0;
         m_instr = 0; m_load = 0;
         m_pc_en = 0; m_gpr = 0; m_aerr = 0; m_berr = 0;
         return;
      end
      if (!m_valid) return;
      m_pc_en = 0; m_gpr = 0; m_aerr = 0; m_berr = 0;
      if (m_phase == 1) begin
         if (!load_req && !store_req) begin
            m_gpr = 1; m_pc_en = 1; m_phase = 0;
         end else if ((load_req && store_req) || alu_addr[1:0] != 0) begin
            m_aerr = 1; m_pc_en = 1; m_phase = 0;
         end else begin
            m_phase = load_req ? 2 : 3;
         end
         m_spent = 0;
         return;
      end
      done    = ram_ready;
      expired = !ram_ready && (m_spent + 1 == TMO);
      if (done) begin
         if (m_phase == 0) begin
            m_instr = ram_rdata; m_phase = 1;
         end else begin
            if (m_phase == 2) begin
               m_load = ram_rdata; m_gpr = 1;
            end
            m_pc_en = 1; m_phase = 0;
         end
         m_spent = 0;
      end else if (expired) begin
         m_berr  = 1;
         m_pc_en = (m_phase != 0);
         m_phase = 0;
         m_spent = 0;
      end else begin
         m_spent++;
      end
   endtask

   // One clock: check with the inputs already applied, then take the edge.
   task automatic cycle();
      #1;
      if (m_valid) compare_model();
      step_model();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load_req = 0; store_req = 0; ram_ready = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; pc = 0; alu_addr = 0; store_data = 0; ram_rdata = 0;
      load_req = 0; store_req = 0; ram_ready = 0;
      cycle(); cycle();
      // Reset state (rst still high)
      check("rst_instr", instr, 32'h0);
      check("rst_load_data", load_data, 32'h0);
      check("rst_pc_en", pc_en, 1'b0);
      check("rst_E", E, 1'b1);
      check("rst_ram_re", ram_re, 1'b0);

      // Zero-wait ALU instruction
      rst = 0; pc = 32'h0; ram_rdata = 32'h01095020; ram_ready = 1;
      cycle();
      check("alu_instr", instr, 32'h01095020);
      check("alu_E_exec", E, 1'b0);
      cycle();
      check("alu_pc_en", pc_en, 1'b1);
      check("alu_gpr_we", gpr_we_en, 1'b1);
      check("alu_E_back", E, 1'b1);

      // Load with 3 wait cycles
      ram_rdata = 32'h8C010010; ram_ready = 1;
      cycle();
      alu_addr = 32'h10; load_req = 1; ram_ready = 0;
      cycle();
      load_req = 0;
      for (int i = 0; i < 4; i++) begin
         ram_ready = (i == 3);
         ram_rdata = 32'hCAFEF00D;
         #1;
         check("ld_ram_re", ram_re, 1'b1);
         check("ld_ram_addr", ram_addr, 30'h4);
         cycle();
      end
      check("ld_data", load_data, 32'hCAFEF00D);
      check("ld_pc_en", pc_en, 1'b1);
      check("ld_gpr_we", gpr_we_en, 1'b1);
      ram_ready = 0;
      cycle();
      check("ld_pc_en_once", pc_en, 1'b0);

      // Store with one wait cycle
      ram_ready = 1; ram_rdata = 32'hAC020020;
      cycle();
      store_req = 1; alu_addr = 32'h20; store_data = 32'hDEADBEEF; ram_ready = 0;
      cycle();
      store_req = 0;
      #1;
      check("st_ram_we", ram_we, 1'b1);
      check("st_ram_re", ram_re, 1'b0);
      check("st_ram_addr", ram_addr, 30'h8);
      check("st_wdata", ram_wdata, 32'hDEADBEEF);
      cycle();
      ram_ready = 1;
      cycle();
      check("st_pc_en", pc_en, 1'b1);
      check("st_gpr_we", gpr_we_en, 1'b0);

      // Misaligned load, then conflicting load+store
      for (int k = 0; k < 2; k++) begin
         ram_ready = 1;
         cycle();
         ram_ready = 0; load_req = 1; store_req = (k == 1);
         alu_addr = (k == 0) ? 32'h13 : 32'h10;
         #1;
         check("err_no_re", ram_re, 1'b0);
         check("err_no_we", ram_we, 1'b0);
         cycle();
         idle_inputs();
         check("err_addr_err", addr_err, 1'b1);
         check("err_pc_en", pc_en, 1'b1);
         check("err_gpr_we", gpr_we_en, 1'b0);
      end

      // Fetch timeout, retried at the same address
      pc = 32'h40; ram_ready = 0;
      for (int i = 0; i < TMO; i++) cycle();
      check("to_bus_err", bus_err, 1'b1);
      check("to_pc_en", pc_en, 1'b0);
      check("to_E", E, 1'b1);
      check("to_retry_addr", ram_addr, 30'h10);

      // Ready on the last allowed wait cycle counts as success
      for (int i = 0; i < TMO; i++) begin
         ram_ready = (i == TMO - 1);
         ram_rdata = 32'h00000000;
         cycle();
      end
      check("edge_bus_err", bus_err, 1'b0);
      check("edge_E_exec", E, 1'b0);

      // Reset in the middle of a store
      store_req = 1; alu_addr = 32'h24; ram_ready = 0;
      cycle();
      store_req = 0;
      #1;
      check("rs_we_before", ram_we, 1'b1);
      rst = 1;
      cycle();
      rst = 0;
      #1;
      check("rs_we_after", ram_we, 1'b0);
      check("rs_E", E, 1'b1);
      check("rs_fetch_re", ram_re, 1'b1);
      check("rs_fetch_addr", ram_addr, 30'h10);
      cycle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst        = ($urandom_range(99) == 0);
         ram_ready  = ($urandom_range(99) < 40);
         ram_rdata  = $urandom;
         pc         = $urandom;
         store_data = $urandom;
         alu_addr   = $urandom;
         if ($urandom_range(3) != 0) alu_addr[1:0] = 2'b00;
         load_req   = ($urandom_range(2) == 0);
         store_req  = ($urandom_range(2) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_phase_ctrl.md
MEM_PHASE_CTRL -- requirements
Module: mem_phase_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum number of wait cycles on one RAM access before abort; legal range is 2..255.
REQ-002 Port clk, input, 1, is the single core clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1, is a synchronous, active-high reset.
REQ-004 Port pc, input, 32, is the current program counter.
REQ-005 Port alu_addr, input, 32, is the data byte address from the execute stage.
REQ-006 Port store_data, input, 32, is the store data (GPR rt).
REQ-007 Port load_req, input, 1, is the decoded load instruction, sampled only in EXEC.
REQ-008 Port store_req, input, 1, is the decoded store instruction, sampled only in EXEC.
REQ-009 Port ram_rdata, input, 32, is the RAM read data, valid when ram_ready=1.
REQ-010 Port ram_ready, input, 1, is the RAM access completion.
REQ-011 Port ram_addr, output, 30, is the RAM word address.
REQ-012 Port ram_wdata, output, 32, is the RAM write data.
REQ-013 Port ram_re, output, 1, is the read strobe.
REQ-014 Port ram_we, output, 1, is the write strobe.
REQ-015 Port E, output, 1, is the fetch-phase flag, 1 in FETCH only.
REQ-016 Port instr, output, 32, is the latched instruction register.
REQ-017 Port load_data, output, 32, is the latched load word.
REQ-018 Port pc_en, output, 1, is a one-cycle PC advance pulse.
REQ-019 Port gpr_we_en, output, 1, is a one-cycle GPR write permit.
REQ-020 Port addr_err, output, 1, is a one-cycle misalignment/conflict pulse.
REQ-021 Port bus_err, output, 1, is a one-cycle timeout pulse.

Function
REQ-022 The FSM SHALL have states FETCH, EXEC, LOAD, and STORE.
REQ-023 In FETCH, the block SHALL drive ram_re=1, ram_addr=pc[31:2], and E=1; on ram_ready it SHALL latch instr<=ram_rdata and go to EXEC; otherwise it SHALL hold.
REQ-024 In EXEC, with E=0, the block SHALL sample load_req/store_req once and take exactly one of the actions in REQ-025 to REQ-028.
REQ-025 In EXEC, if neither request is set, the block SHALL pulse gpr_we_en and pc_en and go to FETCH (EXEC lasts 1 cycle).
REQ-026 In EXEC, if only load_req is set and alu_addr[1:0]==0, the block SHALL go to LOAD.
REQ-027 In EXEC, if only store_req is set and alu_addr[1:0]==0, the block SHALL go to STORE.
REQ-028 In EXEC, if both requests are set, or either is set with alu_addr[1:0]!=0, the block SHALL pulse addr_err and pc_en, keep gpr_we_en=0, make no RAM access, and go to FETCH.
REQ-029 In LOAD, the block SHALL drive ram_re=1 and ram_addr=alu_addr[31:2]; on ram_ready it SHALL latch load_data<=ram_rdata, pulse gpr_we_en and pc_en, and go to FETCH.
REQ-030 In STORE, the block SHALL drive ram_we=1, ram_addr=alu_addr[31:2], and ram_wdata=store_data; on ram_ready it SHALL pulse pc_en (gpr_we_en=0) and go to FETCH.
REQ-031 ram_re and ram_we SHALL never be 1 simultaneously, and both SHALL be 0 in EXEC.
REQ-032 An 8-bit wait counter SHALL clear on every state entry and increment each cycle in FETCH/LOAD/STORE while ram_ready=0.
REQ-033 When the wait counter reaches TIMEOUT-1 with ram_ready=0, the block SHALL pulse bus_err and go to FETCH.
REQ-034 On a FETCH timeout, pc_en SHALL be 0, so the same pc is retried.
REQ-035 On a LOAD/STORE timeout, pc_en SHALL be 1, gpr_we_en SHALL be 0, and instr and load_data SHALL be unchanged.
REQ-036 ram_ready arriving in the same cycle as the timeout threshold SHALL count as success; bus_err SHALL be 0.
REQ-037 ram_ready asserted in EXEC SHALL be ignored.
REQ-038 pc_en, gpr_we_en, addr_err, and bus_err SHALL each be high for at most one cycle per instruction.
REQ-039 instr SHALL change only on FETCH completion, and load_data SHALL change only on LOAD completion.
REQ-040 Minimum latency SHALL be 2 cycles per ALU instruction and 3 per load/store with zero-wait RAM (ram_ready high in the first cycle of each access).

Reset
REQ-041 With rst=1 at a clock edge, the block SHALL enter state FETCH, clear the wait counter, set instr=0 and load_data=0, and drive pc_en, gpr_we_en, addr_err, and bus_err to 0.
REQ-042 While rst=1, the block SHALL drive ram_re=0 and ram_we=0, override FSM outputs, and hold E=1.
REQ-043 Reset mid-STORE SHALL drop ram_we at the next edge; no partial state SHALL be retained, and the first post-reset access SHALL be a fetch at pc.

Verification
REQ-044 Zero-wait RAM, ALU instruction: release reset with pc=0x0, ram_rdata=0x01095020, ram_ready=1 -> next edge instr=0x01095020, E=0; the following cycle pc_en=1, gpr_we_en=1; E=1 after 2 cycles.
REQ-045 Load with 3 wait cycles: alu_addr=0x00000010, load_req=1 -> ram_addr=0x4, ram_re held 4 cycles; load_data=ram_rdata; gpr_we_en and pc_en pulse together exactly once.
REQ-046 Store: store_req=1, alu_addr=0x20, store_data=0xDEADBEEF -> ram_we=1, ram_addr=0x8, ram_wdata=0xDEADBEEF until ready; gpr_we_en stays 0.
REQ-047 Misaligned and conflicting requests: load_req=1 with alu_addr=0x13, then load_req=store_req=1 with alu_addr=0x10 -> addr_err and pc_en each pulse once, with no ram_re/ram_we in either case.
REQ-048 Timeout: TIMEOUT=4, ram_ready held 0 in FETCH -> bus_err pulses after 4 cycles, pc_en=0, and fetch is retried at the same address.
REQ-049 Timeout boundary and reset: ram_ready=1 at the 4th wait cycle -> success, no bus_err; rst=1 during STORE -> ram_we=0 after the edge and state returns to FETCH.
